instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Multicycle instruction fetch stage that sits directly upstream of the processor datapath/control unit. It owns the program counter, issues word reads to the byte-organised 512x8 memory over the MOV/MemRead/MOC handshake, and latches each fetched word into an instruction register. It presents the word to the processor's `instruction` input through a valid/ready handshake. It also accepts branch/jump redirects from the control unit.

## Interface
- `ADDR_W`, 9: byte-address width; matches the 512-byte memory.
- `RESET_PC`, 0: PC value loaded on reset; bits [1:0] are ignored and forced to 0.
- `MOC_TIMEOUT`, 15: maximum number of FETCH cycles the unit waits for MOC before it flags an error (range 1..15).

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `mem_addr`  out  ADDR_W  byte address of the word being fetched; always word-aligned.
- `mem_mov`  out  1  memory operation valid.
- `mem_read`  out  1  read strobe; equal to `mem_mov`, since this block never writes.
- `mem_data`  in  32  big-endian word {Mem[a],Mem[a+1],Mem[a+2],Mem[a+3]}.
- `mem_moc`  in  1  memory operation complete; sampled on `clock`.
- `instr`  out  32  instruction register.
- `instr_valid`  out  1  `instr` holds a word not yet accepted.
- `instr_ready`  in  1  processor accepts `instr` at this edge.
- `pc`  out  ADDR_W  byte address of the word currently in `instr`.
- `redirect`  in  1  load a new fetch address.
- `redirect_pc`  in  ADDR_W  new fetch address; bits [1:0] are forced to 0.
- `fetch_error`  out  1  MOC timeout occurred.

## Operation
- State machine: IDLE, FETCH, HOLD, ERR. Internal `fetch_pc` (ADDR_W bits) and a 4-bit `wait_cnt`.
- Reset values:
  - state=IDLE, `fetch_pc`=RESET_PC, `wait_cnt`=0.
  - `instr`=0, `pc`=0.
  - `instr_valid`, `mem_mov`, `mem_read` and `fetch_error` all 0.
  - `mem_addr` = `fetch_pc`.
- IDLE -> FETCH unconditionally at the first edge after reset is released.
- FETCH:
  - `mem_mov`=`mem_read`=1 and `mem_addr`=`fetch_pc`, held stable for the whole state.
  - Edge with `mem_moc`=1: `instr`<=`mem_data`, `pc`<=`fetch_pc`, `instr_valid`<=1, `wait_cnt`<=0, go to HOLD.
  - Edge with `mem_moc`=0: `wait_cnt`+=1. When the incremented value equals MOC_TIMEOUT, go to ERR.
- HOLD:
  - `mem_mov`=0; this guarantees at least one low MOV cycle between accesses, which the memory needs to see a new transaction.
  - Edge with `instr_ready`=1: `instr_valid`<=0, `fetch_pc`<=`fetch_pc`+4, go to FETCH.
  - While `instr_ready`=0, `instr` and `pc` hold.
- ERR:
  - `fetch_error`=1, `mem_mov`=0, `instr_valid`=0.
  - Left only by reset or `redirect`.
- Redirect (any state except IDLE):
  - At an edge with `redirect`=1: `fetch_pc`<=`redirect_pc` & ~3, `instr_valid`<=0, `wait_cnt`<=0, `fetch_error`<=0, go to FETCH next cycle after one cycle with `mem_mov`=0.
  - To get that low cycle, the unit passes through HOLD with `instr_valid`=0 and treats it as an empty hold that exits automatically.
- Priority at a single edge: reset > redirect > `mem_moc`/`instr_ready`.
  - A word returning at the same edge as `redirect` is discarded.
  - An accept coinciding with `redirect` does not increment the PC.
- Arithmetic: `fetch_pc`+4 wraps modulo 2^ADDR_W; 508+4 gives 0 for ADDR_W=9. No carry or flag is produced.
- `mem_moc` sampled outside FETCH is ignored.

## Timing
- Best case is 2 cycles per instruction with `instr_ready` held high: FETCH (MOC seen at its first edge), then HOLD for 1 cycle.
- First instruction after reset release:
  - Edge 1: IDLE->FETCH.
  - `mem_mov` rises after edge 1.
  - `instr_valid` rises after the first edge at which `mem_moc`=1, earliest edge 2.
- `instr_valid` stays high until the accepting edge and drops immediately after it.
- `instr` changes only on a MOC capture edge.
- Timeout: ERR is entered at the MOC_TIMEOUT-th consecutive FETCH edge with `mem_moc`=0.
- Reset asserted mid-FETCH: `mem_mov` drops asynchronously and the captured data is lost.
- `mem_addr` never changes while `mem_mov`=1.

## Test plan
- Reset release, memory returns 0x2401002C at byte 0 with `mem_moc` high at the second edge, `instr_ready`=1 -> `instr_valid` after edge 2 with `instr`=0x2401002C and `pc`=0; `mem_mov` low for exactly 1 cycle; next `mem_addr`=4.
- `instr_ready` held 0 for 5 cycles in HOLD -> `instr`, `pc` and `instr_valid`=1 stable; `mem_mov`=0 throughout; fetch of address 4 starts 1 edge after `instr_ready` rises.
- `fetch_pc`=508 and word accepted -> next `mem_addr`=0 (wrap).
- `redirect`=1 with `redirect_pc`=0x2E asserted at the same edge as `mem_moc`=1 -> returned word discarded, `instr_valid` stays 0, one `mem_mov`-low cycle, then a fetch at `mem_addr`=0x2C.
- `mem_moc` held 0, MOC_TIMEOUT=15 -> `fetch_error`=1 and `mem_mov`=0 after the 15th FETCH edge; a later `redirect` to 0 clears the error and refetches 0.
- Reset pulsed asynchronously mid-FETCH -> all outputs 0 without waiting for a clock edge; after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Multicycle instruction fetch: owns the PC, reads words over the MOV/MemRead/MOC
// handshake and hands each one to the datapath through a valid/ready register.
module instruction_fetch_unit #(
   parameter int                ADDR_W      = 9,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                MOC_TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_mov,
   output logic              mem_read,
   input  logic [31:0]       mem_data,
   input  logic              mem_moc,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              fetch_error
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_ERR   = 2'd3;

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;
   localparam logic [3:0]        TIMEOUT    = 4'(MOC_TIMEOUT);

   logic [1:0]        state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [3:0]        wait_cnt;

   // MOV is a pure decode of state so an async reset drops it immediately
   assign mem_mov     = (state == S_FETCH);
   assign mem_read    = mem_mov;
   assign mem_addr    = fetch_pc;
   assign fetch_error = (state == S_ERR);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         fetch_pc    <= PC_RST;
         wait_cnt    <= '0;
         instr       <= '0;
         pc          <= '0;
         instr_valid <= 1'b0;
      end else if (state != S_IDLE && redirect) begin
         // Park in an empty HOLD so MOV is low for one cycle before the new fetch
         fetch_pc    <= redirect_pc & ALIGN_MASK;
         instr_valid <= 1'b0;
         wait_cnt    <= '0;
         state       <= S_HOLD;
      end else begin
         case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (mem_moc) begin
                  instr       <= mem_data;
                  pc          <= fetch_pc;
                  instr_valid <= 1'b1;
                  wait_cnt    <= '0;
                  state       <= S_HOLD;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
                  if (wait_cnt + 4'd1 == TIMEOUT) state <= S_ERR;
               end
            end
            S_HOLD: begin
               if (!instr_valid) begin
                  state <= S_FETCH;
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  fetch_pc    <= fetch_pc + WORD_STEP;
                  state       <= S_FETCH;
               end
            end
            default: state <= S_ERR;
         endcase
      end
   end

endmodule
